// File: rtl/sseg_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with PWM dimming, leading-zero
// suppression and frame-synchronous double-buffered value loading.
module sseg_scan_mux #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE_W = 16,
    parameter int DUTY_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   vals,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic [DUTY_W-1:0]     brightness,
    input  logic                  load,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            sseg,
    output logic                  dp_out,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [4*DIGITS-1:0]   pend_vals_q;
    logic [DIGITS-1:0]     pend_dp_q, pend_blank_q;
    logic                  pend_lz_q;
    logic                  pend_valid_q, pend_valid_d;

    logic [4*DIGITS-1:0]   disp_vals_q;
    logic [DIGITS-1:0]     disp_dp_q, disp_blank_q;
    logic                  disp_lz_q;

    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            sseg_q, sseg_d;
    logic                  dp_out_q, dp_out_d;
    logic                  load_ack_q, frame_start_q;

    logic                  tick, boundary, pwm_on;
    logic [DIGITS:0]       zero_above;
    logic [DIGITS-1:0]     dark;
    logic [3:0]            cur_nib;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b0000001;
            4'h1: font = 7'b1001111;
            4'h2: font = 7'b0010010;
            4'h3: font = 7'b0000110;
            4'h4: font = 7'b1001100;
            4'h5: font = 7'b0100100;
            4'h6: font = 7'b0100000;
            4'h7: font = 7'b0001111;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0000100;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b1100000;
            4'hC: font = 7'b0110001;
            4'hD: font = 7'b1000010;
            4'hE: font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
    endfunction

    assign tick     = &presc_q;
    assign boundary = tick && (idx_q == LAST_IDX);

    // zero_above[k]: nibbles k..DIGITS-1 of the shown value are all zero
    assign zero_above[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign zero_above[gi] = (disp_vals_q[4*gi +: 4] == 4'd0) && zero_above[gi+1];
            if (gi == 0) begin : g_lsd
                assign dark[gi] = disp_blank_q[gi];
            end else begin : g_upper
                assign dark[gi] = disp_blank_q[gi] | (disp_lz_q & zero_above[gi]);
            end
        end
    endgenerate

    assign cur_nib = disp_vals_q[{idx_q, 2'b00} +: 4];
    assign pwm_on  = (&brightness) || (presc_q[PRESCALE_W-1 -: DUTY_W] < brightness);

    always_comb begin
        presc_d      = presc_q + 1'b1;
        idx_d        = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        pend_valid_d = load | (pend_valid_q & ~boundary);

        an_d     = '1;
        sseg_d   = 7'h7F;
        dp_out_d = 1'b1;
        if (!dark[idx_q]) begin
            sseg_d   = font(cur_nib);
            dp_out_d = ~disp_dp_q[idx_q];
            if (pwm_on) begin
                an_d = ~(DIGITS'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            pend_vals_q   <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            pend_lz_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            disp_vals_q   <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '1;
            disp_lz_q     <= 1'b0;
            an_q          <= '1;
            sseg_q        <= 7'h7F;
            dp_out_q      <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            pend_valid_q  <= pend_valid_d;
            if (load) begin
                pend_vals_q  <= vals;
                pend_dp_q    <= dp;
                pend_blank_q <= blank;
                pend_lz_q    <= lz_en;
            end
            // Only a load registered before the boundary cycle is promoted here
            if (boundary && pend_valid_q) begin
                disp_vals_q  <= pend_vals_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
                disp_lz_q    <= pend_lz_q;
            end
            an_q          <= an_d;
            sseg_q        <= sseg_d;
            dp_out_q      <= dp_out_d;
            load_ack_q    <= boundary & pend_valid_q;
            frame_start_q <= boundary;
        end
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign dp_out      = dp_out_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
Parametrised multi-digit time-multiplexed 7-segment display driver. It is the successor to the fixed 4-digit scanner and adds:
- a configurable digit count and refresh rate
- per-digit decimal point and blanking
- leading-zero suppression
- PWM brightness
- double-buffered value loading, with new values applied only on frame boundaries so no tearing is visible

It sits between the piano note/score logic and the board's anode and segment pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
PRESCALE_W, 16, prescaler width; each digit slot lasts 2^PRESCALE_W clk cycles
DUTY_W, 4, brightness resolution in bits (DUTY_W <= PRESCALE_W)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
vals  input  4*DIGITS  hex nibble per digit; digit i = vals[4i+3:4i]; digit 0 is rightmost
dp  input  DIGITS  decimal point request per digit, 1 = lit
blank  input  DIGITS  per-digit force-off, 1 = digit dark
lz_en  input  1  leading-zero suppression enable
brightness  input  DUTY_W  PWM level; 0 = off, all-ones = full on
load  input  1  one-cycle strobe; captures vals/dp/blank/lz_en into the pending buffer
load_ack  output  1  one-cycle pulse when the pending buffer is copied into the display buffer
an  output  DIGITS  anode enables, active-low
sseg  output  7  segments, active-low; sseg[6]=a … sseg[0]=g
dp_out  output  1  decimal point, active-low
frame_start  output  1  one-cycle pulse when digit index wraps to 0

Behaviour:
- Reset (async, while high): prescaler=0, idx=0, pending_valid=0, display vals=0, dp=0, blank=all ones, lz_en=0; an=all ones, sseg=7'h7F, dp_out=1, load_ack=0, frame_start=0. Display is dark until the first load is applied.
- Prescaler counts every clk and wraps at all ones. tick = prescaler all ones.
- On tick, idx increments and wraps from DIGITS-1 to 0. The wrap cycle is the frame boundary.
- Load path:
  - On load=1, copy inputs into the pending buffer and set pending_valid=1.
  - Multiple loads before a boundary: the last one wins.
  - At the boundary, if pending_valid was set before this cycle, copy pending into the display buffer, clear pending_valid, and pulse load_ack for that cycle.
  - A load asserted in the boundary cycle itself is applied at the next boundary. pending_valid stays set.
- frame_start pulses in the same cycle as the boundary. load_ack, when it fires, is coincident with frame_start.
- Digit selection for the current idx, using display-buffer contents:
  - Suppression: digit k is suppressed if lz_en=1, k != 0, and nibbles k..DIGITS-1 are all zero. Digit 0 is never suppressed.
  - A digit is dark if it is blank[k] or suppressed. A dark digit has an[k]=1, sseg=7'h7F, dp_out=1.
- PWM: on = (brightness == all ones) OR (prescaler[PRESCALE_W-1 -: DUTY_W] < brightness). When off, all anodes are 1. Segments may still be driven.
- Font, hex 0..F (active-low, abcdefg): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Outputs are registered with 1-cycle latency: an/sseg/dp_out reflect idx and prescaler from the previous cycle. At most one an bit is low at any time.
- Reset asserted mid-frame returns immediately to the reset values above. A pending load is discarded.

Test Plan:
1. Reset, then PRESCALE_W=4, DIGITS=4. Load vals=16'h12AF, dp=4'b0100, blank=0, brightness=all ones -> after the first frame_start (with load_ack), slots show an=1110/F (0111000), 1101/A (0001000), 1011/2 with dp_out=0, 0111/1. Each slot lasts 16 cycles with 1-cycle output lag.
2. Load at non-boundary, then load again before the boundary with a different value -> only the second value appears; load_ack is a single pulse coincident with frame_start.
3. load asserted exactly in the boundary cycle -> no load_ack that cycle; applied with load_ack at the following frame_start.
4. lz_en=1, vals=16'h0030 -> digits 3 and 2 dark (an high in their slots); digit 1 shows 3, digit 0 shows 0. vals=0 -> only digit 0 shows 0.
5. DUTY_W=4, brightness=4 -> anode low for the first 4 of every 16 cycles of each slot. brightness=0 -> an stays all ones.
6. Assert reset asynchronously mid-slot with a load pending -> an=all ones and sseg=7'h7F immediately. After release the display stays dark and no load_ack fires until a new load.
